// File: rtl/phy_pkg.sv
// Shared PHY transmit-path definitions: lane limits, pointer sizing and lane slicing.
package phy_pkg;

  // Widest striping configuration supported by the transmit path.
  localparam int LANES_MAX = 8;

  // Default lane word width; also the stride between lanes in a packed group.
  localparam int LANE_W_DEFAULT = 32;

  // Bits needed to index n slots, never less than one.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    if (r < 1) begin
      r = 1;
    end else begin
      r = r;
    end
    return r;
  endfunction

  // Low bit of lane k inside a packed group of w-bit lanes.
  function automatic int lane_lsb(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/stripe_out_stage.sv
// Output register for one lane group: holds the group until it is consumed
// and counts consumed groups to produce the group sequence number.
module stripe_out_stage
  import phy_pkg::*;
#(
  parameter int DATA_W = LANE_W_DEFAULT,
  parameter int LANES  = 4,
  parameter int SEQ_W  = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_load,
  input  logic [LANES*DATA_W-1:0] i_data,
  input  logic [LANES-1:0]        i_vld,
  input  logic                    i_ready,
  output logic                    o_valid,
  output logic [LANES*DATA_W-1:0] o_data,
  output logic [LANES-1:0]        o_vld,
  output logic [SEQ_W-1:0]        o_seq
);

  logic                    r_valid;
  logic [LANES*DATA_W-1:0] r_data;
  logic [LANES-1:0]        r_vld;
  logic [SEQ_W-1:0]        r_seq;
  logic                    w_consume;

  assign w_consume = r_valid && i_ready;

  // Group register: a new load wins over a consume so both can happen on one edge.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_vld   <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_vld   <= i_vld;
    end else if (w_consume) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_vld   <= '0;
    end else begin
      r_valid <= r_valid;
      r_data  <= r_data;
      r_vld   <= r_vld;
    end
  end

  // Sequence number advances once per consumed group and wraps naturally.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_seq <= '0;
    end else if (w_consume) begin
      r_seq <= r_seq + SEQ_W'(1);
    end else begin
      r_seq <= r_seq;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_vld   = r_vld;
  assign o_seq   = r_seq;

endmodule

// File: rtl/byte_striping_nlane.sv
// N-lane round-robin word striper: collects LANES words into a group (or a
// shorter group on flush) and hands it to a held output stage.
module byte_striping_nlane
  import phy_pkg::*;
#(
  parameter int DATA_W = LANE_W_DEFAULT,
  parameter int LANES  = 4,
  parameter int SEQ_W  = 8
) (
  input  logic                    clk_f,
  input  logic                    reset_L,
  input  logic [DATA_W-1:0]       data_in,
  input  logic                    valid_in,
  output logic                    ready_in,
  input  logic                    flush_in,
  output logic [LANES*DATA_W-1:0] lanes_out,
  output logic [LANES-1:0]        valid_out,
  output logic                    group_valid,
  input  logic                    group_ready,
  output logic [SEQ_W-1:0]        group_seq
);

  localparam int PTR_W = clog2(LANES);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(LANES - 1);

  logic [PTR_W-1:0]              r_ptr;
  logic [LANES-1:0][DATA_W-1:0]  r_slot_data;
  logic [LANES-1:0]              r_slot_vld;
  logic                          r_flush_pend;

  logic                    w_out_free;
  logic                    w_accept;
  logic [CNT_W-1:0]        w_cnt_after;
  logic                    w_full_close;
  logic                    w_flush_req;
  logic                    w_close;
  logic [LANES*DATA_W-1:0] w_grp_data;
  logic [LANES-1:0]        w_grp_vld;

  // The output stage can take a group if it is empty or is being consumed now.
  assign w_out_free   = !group_valid || group_ready;
  // Only the word that would close a group waits on the output stage.
  assign ready_in     = (r_ptr != PTR_LAST) || w_out_free;
  assign w_accept     = valid_in && ready_in;
  assign w_cnt_after  = {1'b0, r_ptr} + {{PTR_W{1'b0}}, w_accept};
  assign w_full_close = w_accept && (r_ptr == PTR_LAST);
  assign w_flush_req  = r_flush_pend || flush_in;
  assign w_close      = w_full_close ||
                        (w_flush_req && (w_cnt_after != CNT_W'(0)) && w_out_free);

  // Assemble the closing group: stored slots plus this cycle's word; empty lanes read zero.
  always_comb begin
    w_grp_data = '0;
    w_grp_vld  = '0;
    for (int k = 0; k < LANES; k++) begin
      if (w_accept && (r_ptr == PTR_W'(k))) begin
        w_grp_data[lane_lsb(k, DATA_W) +: DATA_W] = data_in;
        w_grp_vld[k]                              = 1'b1;
      end else if (r_slot_vld[k]) begin
        w_grp_data[lane_lsb(k, DATA_W) +: DATA_W] = r_slot_data[k];
        w_grp_vld[k]                              = 1'b1;
      end else begin
        w_grp_data[lane_lsb(k, DATA_W) +: DATA_W] = {DATA_W{1'b0}};
        w_grp_vld[k]                              = 1'b0;
      end
    end
  end

  // Collector: write accepted words round-robin, empty on close, track pending flush.
  always_ff @(posedge clk_f) begin
    if (!reset_L) begin
      r_ptr        <= '0;
      r_slot_data  <= '0;
      r_slot_vld   <= '0;
      r_flush_pend <= 1'b0;
    end else if (w_close) begin
      r_ptr        <= '0;
      r_slot_vld   <= '0;
      r_flush_pend <= 1'b0;
    end else begin
      if (w_accept) begin
        r_slot_data[r_ptr] <= data_in;
        r_slot_vld[r_ptr]  <= 1'b1;
        r_ptr              <= r_ptr + PTR_W'(1);
      end
      // A flush against an empty collector is dropped rather than remembered.
      r_flush_pend <= w_flush_req && (w_cnt_after != CNT_W'(0));
    end
  end

  stripe_out_stage #(
    .DATA_W (DATA_W),
    .LANES  (LANES),
    .SEQ_W  (SEQ_W)
  ) u_out (
    .i_clk   (clk_f),
    .i_rst_n (reset_L),
    .i_load  (w_close),
    .i_data  (w_grp_data),
    .i_vld   (w_grp_vld),
    .i_ready (group_ready),
    .o_valid (group_valid),
    .o_data  (lanes_out),
    .o_vld   (valid_out),
    .o_seq   (group_seq)
  );

endmodule

// File: tb/tb_byte_striping_nlane.sv
// Directed bench for byte_striping_nlane at LANES=4, with LANES=2 and 8 for reset.
module tb_byte_striping_nlane;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_l;

  logic [31:0]  d4, d2, d8;
  logic         v4, v2, v8, f4, f2, f8, gr4, gr2, gr8;
  logic         r4, r2, r8, gv4, gv2, gv8;
  logic [127:0] lo4;
  logic [63:0]  lo2;
  logic [255:0] lo8;
  logic [3:0]   vo4;
  logic [1:0]   vo2;
  logic [7:0]   vo8;
  logic [7:0]   sq4, sq2, sq8;

  int total = 0;
  int bad   = 0;

  byte_striping_nlane #(.DATA_W(32), .LANES(4), .SEQ_W(8)) dut4 (
    .clk_f(clk), .reset_L(rst_l), .data_in(d4), .valid_in(v4), .ready_in(r4),
    .flush_in(f4), .lanes_out(lo4), .valid_out(vo4), .group_valid(gv4),
    .group_ready(gr4), .group_seq(sq4));

  byte_striping_nlane #(.DATA_W(32), .LANES(2), .SEQ_W(8)) dut2 (
    .clk_f(clk), .reset_L(rst_l), .data_in(d2), .valid_in(v2), .ready_in(r2),
    .flush_in(f2), .lanes_out(lo2), .valid_out(vo2), .group_valid(gv2),
    .group_ready(gr2), .group_seq(sq2));

  byte_striping_nlane #(.DATA_W(32), .LANES(8), .SEQ_W(8)) dut8 (
    .clk_f(clk), .reset_L(rst_l), .data_in(d8), .valid_in(v8), .ready_in(r8),
    .flush_in(f8), .lanes_out(lo8), .valid_out(vo8), .group_valid(gv8),
    .group_ready(gr8), .group_seq(sq8));

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put4(input logic [31:0] w);
    v4 = 1'b1;
    d4 = w;
    tick();
    v4 = 1'b0;
  endtask

  function automatic logic [127:0] pack4(input logic [31:0] a, b, c, e);
    return {e, c, b, a};
  endfunction

  task automatic do_reset();
    rst_l = 1'b0;
    tick();
    tick();
    rst_l = 1'b1;
  endtask

  initial begin
    int stalls;
    int miss;
    logic [255:0] exp8;
    logic [63:0]  exp2;

    d4 = '0; d2 = '0; d8 = '0;
    v4 = 1'b0; v2 = 1'b0; v8 = 1'b0;
    f4 = 1'b0; f2 = 1'b0; f8 = 1'b0;
    gr4 = 1'b1; gr2 = 1'b1; gr8 = 1'b1;
    do_reset();

    // reset state
    chk("rst_gv",    256'(gv4), 256'(1'b0));
    chk("rst_vo",    256'(vo4), 256'(4'h0));
    chk("rst_lanes", 256'(lo4), 256'(128'h0));
    chk("rst_seq",   256'(sq4), 256'(8'h00));
    chk("rst_ready", 256'(r4),  256'(1'b1));

    // full groups back to back
    put4(32'h11); put4(32'h22); put4(32'h33); put4(32'h44);
    chk("g0_gv",    256'(gv4), 256'(1'b1));
    chk("g0_lanes", 256'(lo4), 256'(pack4(32'h11, 32'h22, 32'h33, 32'h44)));
    chk("g0_vo",    256'(vo4), 256'(4'hF));
    chk("g0_seq",   256'(sq4), 256'(8'd0));
    put4(32'h55);
    chk("g0_consumed_seq", 256'(sq4), 256'(8'd1));
    put4(32'h66); put4(32'h77); put4(32'h88);
    chk("g1_lanes", 256'(lo4), 256'(pack4(32'h55, 32'h66, 32'h77, 32'h88)));
    chk("g1_seq",   256'(sq4), 256'(8'd1));
    tick();
    chk("g1_consumed_gv", 256'(gv4), 256'(1'b0));

    // partial group closed by flush
    put4(32'hAA); put4(32'hBB); put4(32'hCC);
    f4 = 1'b1; tick(); f4 = 1'b0;
    chk("fl_gv",    256'(gv4), 256'(1'b1));
    chk("fl_lanes", 256'(lo4), 256'(pack4(32'hAA, 32'hBB, 32'hCC, 32'h0)));
    chk("fl_vo",    256'(vo4), 256'(4'h7));
    chk("fl_seq",   256'(sq4), 256'(8'd2));
    tick();
    f4 = 1'b1; tick(); f4 = 1'b0;
    chk("fl_empty_gv", 256'(gv4), 256'(1'b0));
    tick();
    chk("fl_empty_gv2", 256'(gv4), 256'(1'b0));
    chk("fl_empty_seq", 256'(sq4), 256'(8'd3));

    // backpressure with a held group
    gr4 = 1'b0;
    put4(32'hD0); put4(32'hD1); put4(32'hD2); put4(32'hD3);
    put4(32'hE0); put4(32'hE1); put4(32'hE2);
    chk("bp_ready_low", 256'(r4), 256'(1'b0));
    v4 = 1'b1; d4 = 32'hE3;
    tick();
    chk("bp_held_lanes", 256'(lo4), 256'(pack4(32'hD0, 32'hD1, 32'hD2, 32'hD3)));
    chk("bp_held_seq",   256'(sq4), 256'(8'd3));
    gr4 = 1'b1;
    #1;
    chk("bp_ready_high", 256'(r4), 256'(1'b1));
    tick();
    v4 = 1'b0;
    chk("bp_new_gv",    256'(gv4), 256'(1'b1));
    chk("bp_new_lanes", 256'(lo4), 256'(pack4(32'hE0, 32'hE1, 32'hE2, 32'hE3)));
    chk("bp_new_seq",   256'(sq4), 256'(8'd4));
    tick();
    chk("bp_done_seq", 256'(sq4), 256'(8'd5));

    // flush on the same cycle as the second accepted word
    v4 = 1'b1; d4 = 32'hF0; tick();
    d4 = 32'hF1; f4 = 1'b1; tick();
    v4 = 1'b0; f4 = 1'b0;
    chk("fa_gv",    256'(gv4), 256'(1'b1));
    chk("fa_lanes", 256'(lo4), 256'(pack4(32'hF0, 32'hF1, 32'h0, 32'h0)));
    chk("fa_vo",    256'(vo4), 256'(4'h3));
    chk("fa_seq",   256'(sq4), 256'(8'd5));
    tick();

    // 257 streamed groups: sequence wraps, no stall at group boundaries
    do_reset();
    stalls = 0;
    miss   = 0;
    for (int g = 0; g < 257; g++) begin
      for (int w = 0; w < 4; w++) begin
        if (!r4) stalls++;
        put4(32'(g * 4 + w));
        v4 = 1'b1;
      end
      if (!gv4) miss++;
      if (g == 255) chk("wrap_seq255", 256'(sq4), 256'(8'd255));
      if (g == 256) begin
        chk("wrap_seq0",  256'(sq4), 256'(8'd0));
        chk("wrap_lanes", 256'(lo4), 256'(pack4(32'd1024, 32'd1025, 32'd1026, 32'd1027)));
      end
    end
    v4 = 1'b0;
    chk("stream_stalls", 256'(stalls), 256'(0));
    chk("stream_miss",   256'(miss),   256'(0));
    tick();

    // reset mid-group with a presented group, at 2, 4 and 8 lanes
    gr4 = 1'b0; gr2 = 1'b0; gr8 = 1'b0;
    for (int c = 0; c < 10; c++) begin
      v4 = (c < 6);  d4 = 32'h100 + 32'(c);
      v2 = (c < 3);  d2 = 32'h100 + 32'(c);
      v8 = 1'b1;     d8 = 32'h100 + 32'(c);
      tick();
    end
    v4 = 1'b0; v2 = 1'b0; v8 = 1'b0;
    chk("mr_pre_gv4", 256'(gv4), 256'(1'b1));
    chk("mr_pre_gv2", 256'(gv2), 256'(1'b1));
    chk("mr_pre_gv8", 256'(gv8), 256'(1'b1));
    rst_l = 1'b0; tick(); rst_l = 1'b1;
    chk("mr4_out", {gv4, vo4, sq4, lo4}, 256'(0));
    chk("mr4_rdy", 256'(r4), 256'(1'b1));
    chk("mr2_out", {gv2, vo2, sq2, lo2}, 256'(0));
    chk("mr2_rdy", 256'(r2), 256'(1'b1));
    chk("mr8_out", 256'(lo8), 256'(0));
    chk("mr8_ctl", {gv8, vo8, sq8}, 256'(0));
    chk("mr8_rdy", 256'(r8), 256'(1'b1));

    gr4 = 1'b1; gr2 = 1'b1; gr8 = 1'b1;
    exp2 = '0;
    exp8 = '0;
    for (int k = 0; k < 8; k++) exp8[k*32 +: 32] = 32'h200 + 32'(k);
    for (int k = 0; k < 2; k++) exp2[k*32 +: 32] = 32'h200 + 32'(k);
    for (int c = 0; c < 8; c++) begin
      v4 = (c < 4); d4 = 32'h200 + 32'(c);
      v2 = (c < 2); d2 = 32'h200 + 32'(c);
      v8 = 1'b1;    d8 = 32'h200 + 32'(c);
      tick();
      if (c == 1) begin
        chk("ar2_lanes", 256'(lo2), 256'(exp2));
        chk("ar2_ctl",   256'({gv2, vo2, sq2}), 256'({1'b1, 2'b11, 8'd0}));
      end
      if (c == 3) begin
        chk("ar4_lanes", 256'(lo4), 256'(pack4(32'h200, 32'h201, 32'h202, 32'h203)));
        chk("ar4_ctl",   256'({gv4, vo4, sq4}), 256'({1'b1, 4'hF, 8'd0}));
      end
      if (c == 7) begin
        chk("ar8_lanes", lo8, exp8);
        chk("ar8_ctl",   256'({gv8, vo8, sq8}), 256'({1'b1, 8'hFF, 8'd0}));
      end
    end
    v4 = 1'b0; v2 = 1'b0; v8 = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/byte_striping_nlane.md
# byte_striping_nlane

Parametrised N-lane byte striper for the PCIe PHY transmit path; successor to the fixed two-lane striper. Accepts one DATA_W word per cycle from the link layer over a valid/ready handshake and distributes consecutive words round-robin across LANES lanes. Presents each completed lane group to the per-lane PHY stages as one aligned, double-buffered group with per-lane valids. Adds backpressure, partial-group flush and a group sequence number.

## Interface
- DATA_W, 32, width of one lane word
- LANES, 4, lane count; power of two, 2..8
- SEQ_W, 8, width of group sequence counter

- clk_f  input  1  single clock; all logic on posedge
- reset_L  input  1  synchronous, active-low reset
- data_in  input  DATA_W  word from link layer
- valid_in  input  1  data_in valid
- ready_in  output  1  block can accept data_in this cycle
- flush_in  input  1  request: close current partial group
- lanes_out  output  LANES*DATA_W  lane k at bits [k*DATA_W +: DATA_W]
- valid_out  output  LANES  per-lane word valid
- group_valid  output  1  output group present
- group_ready  input  1  downstream consumes group
- group_seq  output  SEQ_W  sequence number of presented group

## Operation
- Accept = valid_in && ready_in. The accepted word is written to collection slot ptr, sets slot valid, and ptr increments modulo LANES.
- Group closes when:
  - an accept fills slot LANES-1, or
  - flush_pend (or flush_in this cycle) is set with ptr>0 after this cycle's accept.
- On close: the collection buffer moves to the output stage, ptr<=0, all slot valids clear and flush_pend clears.
- Unfilled lanes of a partial group: valid_out bit 0, data 0.
- flush_in sets flush_pend; pend holds until a group closes. Flush with ptr==0 and no accept is discarded (pend not set).
- Flush in the same cycle as an accept: the word is included, then the group closes.
- Output stage: while group_valid==1 it holds until group_valid && group_ready. Transfer in and out in the same cycle is allowed.
- group_seq increments by 1 per emitted group (on consume), wrapping 2^SEQ_W-1 -> 0. The first group is 0.
- ready_in = (ptr != LANES-1) || !group_valid || group_ready. A close that needs the output stage while it is blocked stalls; flush_pend also waits.
- valid_in with ready_in==0: data_in must be held; not accepted.

## Timing
- Reset (reset_L==0 at a clk_f edge) forces:
  - ptr=0, slot valids=0, flush_pend=0
  - group_valid=0, valid_out=0, lanes_out=0, group_seq=0
  - ready_in=1 on the first cycle after reset.
- Reset mid-group discards collected words and any presented group.
- Latency: the accept of the closing word at edge t gives group_valid=1 after edge t (visible cycle t+1).
- Flush-only close: the edge after flush_in is sampled, when the output stage is free.
- Full throughput: one word per cycle sustained when group_ready is held at 1; no bubbles at group boundaries.
- ready_in is combinational from ptr, group_valid and group_ready. There is no combinational path from valid_in.

## Structure
- Shared package phy_pkg holds:
  - LANES_MAX=8
  - function clog2 for ptr width ($clog2(LANES), min 1)
  - lane slice helper constant.
- Sub-module stripe_out_stage: a parametrised DATA_W*LANES + LANES output register with valid/ready hold and the group_seq counter.
- Collector, ptr and flush logic stay in the top.

## Test plan
- LANES=4, group_ready=1, words 0x11,0x22,0x33,0x44 on consecutive cycles -> one cycle later lanes 0..3 = 11,22,33,44, valid_out=4'b1111, group_seq=0; the next four words give group_seq=1.
- Three words A,B,C then flush_in pulse -> group with lanes 0..2 = A,B,C, lane 3 = 0, valid_out=4'b0111. Flush with ptr==0 -> no group.
- group_ready=0 with a group held, feed 4 more words -> ready_in drops at ptr==3. Raise group_ready -> the held group is consumed and the new group loads the same edge, with no lost or duplicated word.
- Flush asserted on the same cycle as the 2nd word accepted -> group of 2, valid_out=4'b0011.
- Send 257 groups with SEQ_W=8 -> group_seq wraps 255->0->... last = 0.
- reset_L low with ptr=2 and a group presented -> next cycle all outputs 0, ready_in=1. A subsequent full group emits with group_seq=0. Repeat at LANES=2 and LANES=8.
